fpu_divider_sp_seq: RTL

Sequential IEEE-754 single-precision divider, the inverse operation to the combinational single-precision multiplier in the FPU datapath. It accepts `a / b` over a valid/ready handshake and runs a 26-iteration radix-2 restoring mantissa divide. It then rounds round-to-nearest-even and returns one 32-bit result with exception flags. It sits beside the multiplier in the FPU and is driven by the same operand bus.

---
 rtl/fpu_sp_pkg.sv | 25 ++
 rtl/fpu_sp_classify.sv | 27 ++
 rtl/fpu_divider_sp_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared single-precision constants, FSM state encoding and operand layout.
package fpu_sp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;

    localparam int          SP_BIAS = 127;
    localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] SP_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } sp_operand_t;

endpackage

// File: rtl/fpu_sp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
import fpu_sp_pkg::*;

module fpu_sp_classify (
    input  logic [31:0] op_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o,
    output logic        is_denorm_o
);

    sp_operand_t op;
    logic        exp_max;
    logic        exp_min;
    logic        frac_nz;

    assign op      = op_i;
    assign exp_max = (op.exp == '1);
    assign exp_min = (op.exp == '0);
    assign frac_nz = (op.frac != '0);

    assign is_zero_o   = exp_min & ~frac_nz;
    assign is_denorm_o = exp_min &  frac_nz;
    assign is_inf_o    = exp_max & ~frac_nz;
    assign is_nan_o    = exp_max &  frac_nz;

endmodule

// File: rtl/fpu_divider_sp_seq.sv
// Sequential single-precision divider: restoring radix-2 mantissa divide,
// round-to-nearest-even, flush-to-zero for denormal inputs and results.
import fpu_sp_pkg::*;

module fpu_divider_sp_seq #(
    parameter int ITER = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        div_by_zero,
    output logic        invalid
);

    localparam int                CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    sp_operand_t op_a, op_b;
    logic        a_zero, a_inf, a_nan, a_den;
    logic        b_zero, b_inf, b_nan, b_den;

    assign op_a = a;
    assign op_b = b;

    fpu_sp_classify u_cls_a (
        .op_i(a), .is_zero_o(a_zero), .is_inf_o(a_inf), .is_nan_o(a_nan), .is_denorm_o(a_den)
    );
    fpu_sp_classify u_cls_b (
        .op_i(b), .is_zero_o(b_zero), .is_inf_o(b_inf), .is_nan_o(b_nan), .is_denorm_o(b_den)
    );

    div_state_t         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MANT_W:0]    rem_q;
    logic [MANT_W-1:0]  mb_q;
    logic [MANT_W+1:0]  quo_q;
    logic signed [9:0]  exp_q;
    logic               sign_q;
    logic               spec_q;
    logic [31:0]        spec_res_q;
    logic               spec_dbz_q;
    logic               spec_inv_q;
    logic [31:0]        c_q;
    logic               out_valid_q;
    logic               dbz_q;
    logic               inv_q;

    // Special-case resolution on the live operand bus; denormals count as zero.
    logic        sign_d;
    logic        za, zb;
    logic        spec_d;
    logic [31:0] spec_res_d;
    logic        spec_dbz_d;
    logic        spec_inv_d;
    logic signed [9:0] exp_d;

    assign sign_d = op_a.sign ^ op_b.sign;
    assign za     = a_zero | a_den;
    assign zb     = b_zero | b_den;
    assign exp_d  = $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp}) + 10'sd127;

    // Priority-ordered special result selection
    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = SP_QNAN;
        spec_dbz_d = 1'b0;
        spec_inv_d = 1'b0;
        if (a_nan || b_nan) begin
            spec_inv_d = 1'b1;
        end else if ((za && zb) || (a_inf && b_inf)) begin
            spec_inv_d = 1'b1;
        end else if (a_inf) begin
            spec_res_d = {sign_d, SP_INF[30:0]};
        end else if (zb) begin
            spec_res_d = {sign_d, SP_INF[30:0]};
            spec_dbz_d = 1'b1;
        end else if (za || b_inf) begin
            spec_res_d = {sign_d, 31'd0};
        end else begin
            spec_d = 1'b0;
        end
    end

    // One restoring-division step: the remainder after subtraction is always
    // below the divisor, so it fits in the mantissa width before the shift.
    logic                ge;
    logic [MANT_W-1:0]   rem_sub;
    logic [MANT_W:0]     rem_d;
    logic [MANT_W+1:0]   quo_d;

    assign ge      = (rem_q >= {1'b0, mb_q});
    assign rem_sub = ge ? MANT_W'(rem_q - {1'b0, mb_q}) : rem_q[MANT_W-1:0];
    assign rem_d   = {rem_sub, 1'b0};
    assign quo_d   = {quo_q[MANT_W:0], ge};

    // Normalise, round to nearest even and range-check the final exponent
    logic              lead;
    logic [MANT_W-1:0] mant;
    logic              guard, sticky, rnd_up;
    logic [MANT_W:0]   mant_rnd;
    logic [FRAC_W-1:0] frac_rnd;
    logic signed [9:0] exp_rnd;
    logic [31:0]       round_res;

    assign lead     = quo_q[MANT_W+1];
    assign mant     = lead ? quo_q[MANT_W+1:2] : quo_q[MANT_W:1];
    assign guard    = lead ? quo_q[1] : quo_q[0];
    assign sticky   = (lead & quo_q[0]) | (rem_q != '0);
    assign rnd_up   = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
    assign frac_rnd = mant_rnd[MANT_W] ? mant_rnd[FRAC_W:1] : mant_rnd[FRAC_W-1:0];
    assign exp_rnd  = exp_q - $signed({9'd0, ~lead}) + $signed({9'd0, mant_rnd[MANT_W]});

    // Overflow saturates to infinity without a flag; underflow flushes to zero
    always_comb begin
        round_res = {sign_q, exp_rnd[7:0], frac_rnd};
        if (exp_rnd >= 10'sd255) begin
            round_res = {sign_q, SP_INF[30:0]};
        end else if (exp_rnd <= 10'sd0) begin
            round_res = {sign_q, 31'd0};
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            quo_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_dbz_q  <= 1'b0;
            spec_inv_q  <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dbz_q      <= 1'b0;
                        inv_q      <= 1'b0;
                        sign_q     <= sign_d;
                        exp_q      <= exp_d;
                        rem_q      <= {2'b01, op_a.frac};
                        mb_q       <= {1'b1, op_b.frac};
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        spec_q     <= spec_d;
                        spec_res_q <= spec_res_d;
                        spec_dbz_q <= spec_dbz_d;
                        spec_inv_q <= spec_inv_d;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    if (spec_q) begin
                        // Special results bypass the iteration and land one edge after accept
                        c_q         <= spec_res_q;
                        dbz_q       <= spec_dbz_q;
                        inv_q       <= spec_inv_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) state_q <= ROUND;
                    end
                end
                ROUND: begin
                    c_q         <= round_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign c           = c_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;

endmodule
